// File: rtl/button_reader_pkg.sv
// Shared types and default timing for the pushbutton reader.
// Timing defaults assume a 100 MHz clock.
package button_reader_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned LONG_CYCLES_DEF     = 100000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus saturating-run debounce counter.
// rise_c/fall_c flag the edge on which level is about to change.
module button_debounce
    import button_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic RELEASED_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic            sync1;
    logic            sync2;
    logic            btn_s;
    logic            differ_c;
    logic            hit_c;
    logic [DB_W-1:0] db_cnt;

    // Reset loads the released pin level so reset itself never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RELEASED_PIN;
            sync2 <= RELEASED_PIN;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign btn_s    = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign differ_c = (btn_s != level);
    assign hit_c    = differ_c && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign rise_c   = hit_c && btn_s;
    assign fall_c   = hit_c && !btn_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (hit_c) begin
            level  <= btn_s;
            db_cnt <= '0;
        end else if (differ_c) begin
            db_cnt <= db_cnt + DB_W'(1);
        end else begin
            db_cnt <= '0;
        end
    end

endmodule

// File: rtl/button_reader.sv
// Debounced pushbutton with press/release pulses, short/long classification
// and a press-toggled latch; every pulse lands on the first cycle of the new level.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic released,
    output logic short_click,
    output logic long_press,
    output logic toggle
);

    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    state_t              state;
    state_t              state_nxt;
    logic                rise_c;
    logic                fall_c;
    logic                timeout_c;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_nxt;
    logic                press_nxt;
    logic                released_nxt;
    logic                short_click_nxt;
    logic                long_press_nxt;
    logic                toggle_nxt;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .level  (level),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    assign timeout_c = (state == ST_HELD) && (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

    // State, hold counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            press       <= 1'b0;
            released    <= 1'b0;
            short_click <= 1'b0;
            long_press  <= 1'b0;
            toggle      <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            press       <= press_nxt;
            released    <= released_nxt;
            short_click <= short_click_nxt;
            long_press  <= long_press_nxt;
            toggle      <= toggle_nxt;
        end
    end

    // A fall on the timeout edge goes straight to IDLE, so release wins.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (rise_c) state_nxt = ST_HELD;
            ST_HELD: begin
                if (fall_c)         state_nxt = ST_IDLE;
                else if (timeout_c) state_nxt = ST_LONG;
            end
            ST_LONG: if (fall_c) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        press_nxt       = (state == ST_IDLE) && rise_c;
        released_nxt    = (state != ST_IDLE) && fall_c;
        short_click_nxt = (state == ST_HELD) && fall_c;
        long_press_nxt  = timeout_c && !fall_c;
        toggle_nxt      = toggle ^ press_nxt;
        hold_cnt_nxt    = hold_cnt;
        if (press_nxt) begin
            hold_cnt_nxt = '0;
        end else if ((state == ST_HELD) && !fall_c && !timeout_c) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// Directed vector bench for button_reader with short debounce/long timings.
`timescale 1ns/1ps
module tb_button_reader;

    localparam int unsigned DB   = 4;
    localparam int unsigned LONG = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic level, press, released, short_click, long_press, toggle;

    int n_vec = 0;
    int n_err = 0;

    // Expected bits: {level, press, released, short_click, long_press, toggle}
    typedef struct {
        logic       r;
        logic       b;
        logic [5:0] exp;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    button_reader #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LONG),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .level       (level),
        .press       (press),
        .released    (released),
        .short_click (short_click),
        .long_press  (long_press),
        .toggle      (toggle)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic b, input logic [5:0] exp,
                       input int n, input string tag);
        vec_t v;
        v.r = r; v.b = b; v.exp = exp; v.tag = tag;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic step(input logic r, input logic b, input logic [5:0] exp,
                        input string tag);
        logic [5:0] got;
        rst = r;
        btn = b;
        @(posedge clk);
        #1;
        got = {level, press, released, short_click, long_press, toggle};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %b, expected %b  [lvl prs rel shc lng tgl]",
                     tag, n_vec, got, exp);
        end
    endtask

    initial begin
        // Reset, then released pin: nothing happens.
        add(1'b1, 1'b1, 6'b000000, 3,  "s1_rst");
        add(1'b0, 1'b1, 6'b000000, 50, "s1_idle");
        // Bounce with runs shorter than the debounce window.
        add(1'b0, 1'b0, 6'b000000, 2,  "s2_bounce");
        add(1'b0, 1'b1, 6'b000000, 1,  "s2_bounce");
        add(1'b0, 1'b0, 6'b000000, 3,  "s2_bounce");
        add(1'b0, 1'b1, 6'b000000, 2,  "s2_bounce");
        add(1'b0, 1'b0, 6'b000000, 1,  "s2_bounce");
        add(1'b0, 1'b1, 6'b000000, 1,  "s2_bounce");
        add(1'b0, 1'b0, 6'b000000, 5,  "s2_wait");
        add(1'b0, 1'b0, 6'b110001, 1,  "s2_press");
        // Short click.
        add(1'b0, 1'b0, 6'b100001, 6,  "s3_hold");
        add(1'b0, 1'b1, 6'b100001, 5,  "s3_wait_rel");
        add(1'b0, 1'b1, 6'b001101, 1,  "s3_release");
        add(1'b0, 1'b1, 6'b000001, 3,  "s3_idle");
        // Long press held 40 cycles.
        add(1'b0, 1'b0, 6'b000001, 5,  "s4_wait");
        add(1'b0, 1'b0, 6'b110000, 1,  "s4_press");
        add(1'b0, 1'b0, 6'b100000, 15, "s4_hold");
        add(1'b0, 1'b0, 6'b100010, 1,  "s4_long");
        add(1'b0, 1'b0, 6'b100000, 24, "s4_hold_long");
        add(1'b0, 1'b1, 6'b100000, 5,  "s4_wait_rel");
        add(1'b0, 1'b1, 6'b001000, 1,  "s4_release");
        add(1'b0, 1'b1, 6'b000000, 3,  "s4_idle");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].b, tbl[i].exp, tbl[i].tag);
        end

        // Release lands on the same edge as the long timeout.
        repeat (5)  step(1'b0, 1'b0, 6'b000000, "s5_wait");
        step(1'b0, 1'b0, 6'b110001, "s5_press");
        repeat (10) step(1'b0, 1'b0, 6'b100001, "s5_hold");
        repeat (5)  step(1'b0, 1'b1, 6'b100001, "s5_wait_rel");
        step(1'b0, 1'b1, 6'b001101, "s5_collision");
        repeat (20) step(1'b0, 1'b1, 6'b000001, "s5_idle");

        // Extra click to bring toggle back to 0 before the reset test.
        repeat (5)  step(1'b0, 1'b0, 6'b000001, "x_wait");
        step(1'b0, 1'b0, 6'b110000, "x_press");
        repeat (2)  step(1'b0, 1'b0, 6'b100000, "x_hold");
        repeat (5)  step(1'b0, 1'b1, 6'b100000, "x_wait_rel");
        step(1'b0, 1'b1, 6'b001100, "x_release");
        repeat (2)  step(1'b0, 1'b1, 6'b000000, "x_idle");

        // Reset while held: toggle cleared, press must re-debounce.
        repeat (5)  step(1'b0, 1'b0, 6'b000000, "s6_wait");
        step(1'b0, 1'b0, 6'b110001, "s6_press");
        repeat (3)  step(1'b0, 1'b0, 6'b100001, "s6_hold");
        step(1'b1, 1'b0, 6'b000000, "s6_rst");
        step(1'b1, 1'b0, 6'b000000, "s6_rst");
        repeat (5)  step(1'b0, 1'b0, 6'b000000, "s6_rewait");
        step(1'b0, 1'b0, 6'b110001, "s6_repress");
        repeat (2)  step(1'b0, 1'b0, 6'b100001, "s6_rehold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
